seq_stream_ctrl: RTL and testbench
==================================

# seq_stream_ctrl

Sequencing controller for the serial sequence-detector datapath. It holds a loaded bit pattern and clears the detector. It then streams the pattern into the detector one bit per clock, MSB first, and counts the detector's hit pulses, tagging each hit with the index of the bit that completed it. A `start`/`done` handshake lets a host or bench run repeatable detection passes without hand-driving `din` cycle by cycle.

## Interface
- `MAX_LEN`, 64: maximum pattern length in bits.
- `DET_LAT`, 1: detector latency in clocks from `det_din` driven to the matching `det_dout`; legal range 1..4.
- `LEN_W`, $clog2(MAX_LEN+1): width of length and count fields.
- `IDX_W`, $clog2(MAX_LEN): width of bit-index fields.

Ports:
- `clk` in 1: single clock, rising edge.
- `rst` in 1: synchronous, active-high reset.
- `load` in 1: captures `pat_in`/`len_in` in IDLE; ignored in any other state.
- `pat_in` in MAX_LEN: pattern; bit `len-1` is sent first, bit 0 last.
- `len_in` in LEN_W: bits to send; values above MAX_LEN are clamped to MAX_LEN.
- `start` in 1: begin a pass; sampled only in IDLE.
- `abort` in 1: cancel a pass in progress.
- `busy` out 1: high in CLR, SHIFT and DRAIN.
- `done` out 1: one-cycle pulse at the end of a pass.
- `det_rst` out 1: detector reset, high only in CLR.
- `det_din` out 1: serial bit to the detector.
- `det_dout` in 1: detector hit flag.
- `hit_cnt` out LEN_W: hits counted in the current or last pass.
- `first_hit_idx` out IDX_W: stream index (0 = first bit sent) of the first hit.
- `first_hit_vld` out 1: `first_hit_idx` is meaningful.

## Operation
- FSM states are IDLE, CLR, SHIFT, DRAIN, DONE.
- IDLE + `start` goes to CLR. CLR always goes to SHIFT.
  - On entry to CLR, `hit_cnt`, `first_hit_idx` and `first_hit_vld` clear.
  - The bit counter loads the stored length.
- SHIFT drives `det_din` = pattern bit, one bit per cycle, until all bits are sent, then goes to DRAIN.
- DRAIN lasts exactly DET_LAT cycles with `det_din`=0, then goes to DONE.
- DONE lasts one cycle (`done`=1), then goes to IDLE.
- Stored length 0 takes CLR to DONE directly: `hit_cnt`=0, `first_hit_vld`=0.
- Tag pipeline, DET_LAT deep: carries {valid, index} for every bit driven in SHIFT.
  - When the tag emerging this cycle is valid and `det_dout`=1, `hit_cnt` increments.
  - If this is the first hit, `first_hit_idx` takes the emerging index and `first_hit_vld` is set.
- `det_dout` is ignored when the emerging tag is invalid: in CLR, in IDLE, and in the first DET_LAT SHIFT cycles.
- `hit_cnt` cannot exceed the length, so it has no saturation logic.
- `abort` in CLR, SHIFT or DRAIN:
  - Next state is IDLE and `done` is not pulsed.
  - The tag pipeline flushes.
  - Results hold their partial values.
- `abort` is ignored in IDLE and DONE.
- `start` while busy is ignored.
- `load` and `start` in the same IDLE cycle: the new pattern is stored and that pass uses it.
- Results hold after DONE until the next CLR.

## Timing
- Reset values: state IDLE, `busy`=0, `done`=0, `det_rst`=0, `det_din`=0, `hit_cnt`=0, `first_hit_idx`=0, `first_hit_vld`=0, stored pattern and length 0.
- Every output is registered.
- `start` sampled at edge t gives:
  - CLR in cycle t+1;
  - SHIFT in cycles t+2 .. t+1+L;
  - DRAIN in cycles t+2+L .. t+1+L+DET_LAT;
  - `done` in cycle t+2+L+DET_LAT.
- Total latency from `start` to `done` is L+DET_LAT+2 cycles.
- Bit i is on `det_din` in cycle t+2+i. Its hit is sampled in cycle t+2+i+DET_LAT.
- `rst` mid-pass returns to IDLE at the next edge with all outputs at their reset values.
- `rst` has priority over `abort`, `start` and `load`.

## Structure
- Package `seq_ctrl_pkg` holds:
  - the state enum `seq_state_t`;
  - the `MAX_LEN` and `DET_LAT` defaults;
  - localparam width helpers.
- Sub-module `seq_tag_pipe` is a parameterised DET_LAT-stage {valid, index} delay line with a synchronous flush. The top instantiates one.
- The top module holds the FSM, pattern register, bit counter and result registers.

## Test plan
- Bench model: the detector flags "1101" with overlaps, DET_LAT=1.
- Load pattern `11011011`, L=8, start at t:
  - `det_rst` in cycle t+1;
  - bits 1,1,0,1,1,0,1,1 in cycles t+2..t+9;
  - `done` at t+11;
  - `hit_cnt`=2, `first_hit_idx`=3, `first_hit_vld`=1.
- Load `0000` with L=4: `done` at t+7, `hit_cnt`=0, `first_hit_vld`=0.
- L=0: CLR then DONE, so `done` at t+2, `busy` high for one cycle only, no bits driven.
- Abort during SHIFT: same pattern as the first scenario, `abort` in cycle t+7:
  - IDLE in the next cycle, with no `done`;
  - `hit_cnt`=1 and `first_hit_idx`=3 retained.
- `start` and `load` pulsed while busy: ignored, and the current pass results match the first scenario.
- `rst` asserted in cycle t+5 of a pass: all outputs return to reset values at the next edge. A new start then completes normally.

Source files
------------

// File: rtl/seq_ctrl_pkg.sv
// -----------------------------------------------------------------------------
// seq_ctrl_pkg
// Shared types and defaults for the sequence-detector stream controller.
//   seq_state_t : controller FSM state encoding
//   DEF_MAX_LEN : default maximum pattern length in bits
//   DEF_DET_LAT : default detector latency in clocks (legal 1..4)
//   len_width() : width able to hold 0..max_len
//   idx_width() : width able to hold a bit index 0..max_len-1
// -----------------------------------------------------------------------------
package seq_ctrl_pkg;

  localparam int unsigned DEF_MAX_LEN = 64;
  localparam int unsigned DEF_DET_LAT = 1;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_CLR,
    ST_SHIFT,
    ST_DRAIN,
    ST_DONE
  } seq_state_t;

  function automatic int unsigned len_width(input int unsigned max_len);
    return $clog2(max_len + 1);
  endfunction

  function automatic int unsigned idx_width(input int unsigned max_len);
    return (max_len > 1) ? $clog2(max_len) : 1;
  endfunction

endpackage

// File: rtl/seq_tag_pipe.sv
// -----------------------------------------------------------------------------
// seq_tag_pipe
// DEPTH-stage delay line carrying {valid, index} alongside the detector so a
// hit can be attributed to the stream bit that completed it.
//   clk, rst        : clock, synchronous active-high reset
//   flush           : synchronous clear of every stage (and of the input)
//   in_vld, in_idx  : tag entering this cycle
//   out_vld, out_idx: tag emerging this cycle (entered DEPTH cycles ago)
// -----------------------------------------------------------------------------
module seq_tag_pipe #(
  parameter int unsigned DEPTH = 1,
  parameter int unsigned IDX_W = 6
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             in_vld,
  input  logic [IDX_W-1:0] in_idx,
  output logic             out_vld,
  output logic [IDX_W-1:0] out_idx
);

  logic             vld_q [DEPTH];
  logic             vld_d [DEPTH];
  logic [IDX_W-1:0] idx_q [DEPTH];
  logic [IDX_W-1:0] idx_d [DEPTH];

  for (genvar gi = 0; gi < DEPTH; gi++) begin : g_stage
    if (gi == 0) begin : g_head
      assign vld_d[gi] = in_vld && !flush;
      assign idx_d[gi] = in_idx;
    end else begin : g_body
      assign vld_d[gi] = vld_q[gi-1] && !flush;
      assign idx_d[gi] = idx_q[gi-1];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < int'(DEPTH); i++) begin
        vld_q[i] <= 1'b0;
        idx_q[i] <= '0;
      end
    end else begin
      for (int i = 0; i < int'(DEPTH); i++) begin
        vld_q[i] <= vld_d[i];
        idx_q[i] <= idx_d[i];
      end
    end
  end

  assign out_vld = vld_q[DEPTH-1];
  assign out_idx = idx_q[DEPTH-1];

endmodule

// File: rtl/seq_stream_ctrl.sv
// -----------------------------------------------------------------------------
// seq_stream_ctrl
// Streams a stored pattern MSB-first into a serial sequence detector, then
// counts the detector's hit pulses and records the stream index of the first.
//   clk, rst       : clock, synchronous active-high reset
//   load           : capture pat_in / len_in (IDLE only; len clamped to MAX_LEN)
//   start          : begin a pass (IDLE only)
//   abort          : cancel a pass in CLR/SHIFT/DRAIN, no done pulse
//   busy           : high in CLR, SHIFT and DRAIN
//   done           : one-cycle pulse at the end of a completed pass
//   det_rst        : detector reset, high in CLR
//   det_din        : serial bit to the detector
//   det_dout       : detector hit flag, DET_LAT clocks after det_din
//   hit_cnt        : hits counted in the current or last pass
//   first_hit_idx  : stream index of the first hit (0 = first bit sent)
//   first_hit_vld  : first_hit_idx is meaningful
// All outputs are registered; each is computed from the next state.
// -----------------------------------------------------------------------------
module seq_stream_ctrl
  import seq_ctrl_pkg::*;
#(
  parameter int unsigned MAX_LEN = DEF_MAX_LEN,
  parameter int unsigned DET_LAT = DEF_DET_LAT,
  parameter int unsigned LEN_W   = len_width(MAX_LEN),
  parameter int unsigned IDX_W   = idx_width(MAX_LEN)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               load,
  input  logic [MAX_LEN-1:0] pat_in,
  input  logic [LEN_W-1:0]   len_in,
  input  logic               start,
  input  logic               abort,
  output logic               busy,
  output logic               done,
  output logic               det_rst,
  output logic               det_din,
  input  logic               det_dout,
  output logic [LEN_W-1:0]   hit_cnt,
  output logic [IDX_W-1:0]   first_hit_idx,
  output logic               first_hit_vld
);

  localparam logic [LEN_W-1:0] MAX_LEN_L = LEN_W'(MAX_LEN);
  localparam logic [LEN_W-1:0] ONE_L     = LEN_W'(1);

  seq_state_t         state_q, state_d;
  logic [MAX_LEN-1:0] pat_q, pat_d;
  logic [LEN_W-1:0]   len_q, len_d;
  // Remaining bits (including the one on det_din) in SHIFT; remaining
  // drain cycles in DRAIN.
  logic [LEN_W-1:0]   cnt_q, cnt_d;
  logic [LEN_W-1:0]   hit_cnt_q, hit_cnt_d;
  logic [IDX_W-1:0]   first_hit_idx_q, first_hit_idx_d;
  logic               first_hit_vld_q, first_hit_vld_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;
  logic               det_rst_q, det_rst_d;
  logic               det_din_q, det_din_d;

  logic               do_abort;
  logic               tag_in_vld;
  logic [IDX_W-1:0]   tag_in_idx;
  logic               tag_out_vld;
  logic [IDX_W-1:0]   tag_out_idx;

  assign do_abort   = abort && (state_q inside {ST_CLR, ST_SHIFT, ST_DRAIN});
  // The bit currently on det_din gets a tag; its index is bits already sent.
  assign tag_in_vld = (state_q == ST_SHIFT);
  assign tag_in_idx = IDX_W'(len_q - cnt_q);

  seq_tag_pipe #(
    .DEPTH (DET_LAT),
    .IDX_W (IDX_W)
  ) u_tag_pipe (
    .clk     (clk),
    .rst     (rst),
    .flush   (do_abort),
    .in_vld  (tag_in_vld),
    .in_idx  (tag_in_idx),
    .out_vld (tag_out_vld),
    .out_idx (tag_out_idx)
  );

  always_comb begin
    state_d         = state_q;
    pat_d           = pat_q;
    len_d           = len_q;
    cnt_d           = cnt_q;
    hit_cnt_d       = hit_cnt_q;
    first_hit_idx_d = first_hit_idx_q;
    first_hit_vld_d = first_hit_vld_q;
    det_din_d       = 1'b0;

    // Hit accounting; a hit emerging in the abort cycle is discarded so the
    // results freeze at the abort.
    if (tag_out_vld && det_dout && !do_abort) begin
      hit_cnt_d = hit_cnt_q + ONE_L;
      if (!first_hit_vld_q) begin
        first_hit_idx_d = tag_out_idx;
        first_hit_vld_d = 1'b1;
      end
    end

    case (state_q)
      ST_IDLE: begin
        if (load) begin
          pat_d = pat_in;
          len_d = (len_in > MAX_LEN_L) ? MAX_LEN_L : len_in;
        end
        if (start) begin
          state_d         = ST_CLR;
          hit_cnt_d       = '0;
          first_hit_idx_d = '0;
          first_hit_vld_d = 1'b0;
        end
      end
      ST_CLR: begin
        cnt_d = len_q;
        if (len_q == '0) begin
          state_d = ST_DONE;
        end else begin
          state_d   = ST_SHIFT;
          det_din_d = pat_q[IDX_W'(len_q - ONE_L)];
        end
      end
      ST_SHIFT: begin
        if (cnt_q > ONE_L) begin
          cnt_d     = cnt_q - ONE_L;
          // Next bit to send sits one below the current one.
          det_din_d = pat_q[IDX_W'(cnt_q - LEN_W'(2))];
        end else begin
          state_d = ST_DRAIN;
          cnt_d   = LEN_W'(DET_LAT);
        end
      end
      ST_DRAIN: begin
        if (cnt_q <= ONE_L) begin
          state_d = ST_DONE;
        end else begin
          cnt_d = cnt_q - ONE_L;
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    if (do_abort) begin
      state_d   = ST_IDLE;
      det_din_d = 1'b0;
    end

    busy_d    = (state_d inside {ST_CLR, ST_SHIFT, ST_DRAIN});
    done_d    = (state_d == ST_DONE);
    det_rst_d = (state_d == ST_CLR);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q         <= ST_IDLE;
      pat_q           <= '0;
      len_q           <= '0;
      cnt_q           <= '0;
      hit_cnt_q       <= '0;
      first_hit_idx_q <= '0;
      first_hit_vld_q <= 1'b0;
      busy_q          <= 1'b0;
      done_q          <= 1'b0;
      det_rst_q       <= 1'b0;
      det_din_q       <= 1'b0;
    end else begin
      state_q         <= state_d;
      pat_q           <= pat_d;
      len_q           <= len_d;
      cnt_q           <= cnt_d;
      hit_cnt_q       <= hit_cnt_d;
      first_hit_idx_q <= first_hit_idx_d;
      first_hit_vld_q <= first_hit_vld_d;
      busy_q          <= busy_d;
      done_q          <= done_d;
      det_rst_q       <= det_rst_d;
      det_din_q       <= det_din_d;
    end
  end

  assign busy          = busy_q;
  assign done          = done_q;
  assign det_rst       = det_rst_q;
  assign det_din       = det_din_q;
  assign hit_cnt       = hit_cnt_q;
  assign first_hit_idx = first_hit_idx_q;
  assign first_hit_vld = first_hit_vld_q;

endmodule

// File: tb/tb_seq_stream_ctrl.sv
// -----------------------------------------------------------------------------
// tb_seq_stream_ctrl
// Drives seq_stream_ctrl against a "1101" overlapping detector (latency 1) and
// compares every output, every cycle, with expectations derived from the
// pattern/length and the pass timeline.
// -----------------------------------------------------------------------------
module tb_seq_stream_ctrl;

  localparam int MAX_LEN = 64;
  localparam int DET_LAT = 1;
  localparam int LEN_W   = $clog2(MAX_LEN + 1);
  localparam int IDX_W   = $clog2(MAX_LEN);

  logic               clk    = 1'b0;
  logic               rst    = 1'b1;
  logic               load   = 1'b0;
  logic               start  = 1'b0;
  logic               abort  = 1'b0;
  logic [MAX_LEN-1:0] pat_in = '0;
  logic [LEN_W-1:0]   len_in = '0;
  logic               busy, done, det_rst, det_din;
  logic               det_dout = 1'b0;
  logic [LEN_W-1:0]   hit_cnt;
  logic [IDX_W-1:0]   first_hit_idx;
  logic               first_hit_vld;

  int n_pass   = 0;
  int n_checks = 0;
  int n_txn    = 0;

  // What the controller should currently hold.
  logic [MAX_LEN-1:0] m_pat = '0;
  int                 m_len = 0;

  logic [2:0] det_hist = '0;

  always #5 clk = ~clk;

  seq_stream_ctrl #(
    .MAX_LEN (MAX_LEN),
    .DET_LAT (DET_LAT)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .load          (load),
    .pat_in        (pat_in),
    .len_in        (len_in),
    .start         (start),
    .abort         (abort),
    .busy          (busy),
    .done          (done),
    .det_rst       (det_rst),
    .det_din       (det_din),
    .det_dout      (det_dout),
    .hit_cnt       (hit_cnt),
    .first_hit_idx (first_hit_idx),
    .first_hit_vld (first_hit_vld)
  );

  // Detector: flags "1101" with overlaps, one clock after the last bit.
  always @(posedge clk) begin
    if (rst || det_rst) begin
      det_hist <= '0;
      det_dout <= 1'b0;
    end else begin
      det_hist <= {det_hist[1:0], det_din};
      det_dout <= ({det_hist, det_din} == 4'b1101);
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    n_checks++;
    assert (obs === expv) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
  endtask

  function automatic int clamp_len(input int li);
    return (li > MAX_LEN) ? MAX_LEN : li;
  endfunction

  task automatic load_only(input logic [MAX_LEN-1:0] p, input int li);
    load   = 1'b1;
    pat_in = p;
    len_in = LEN_W'(li);
    m_pat  = p;
    m_len  = clamp_len(li);
    step();
    load   = 1'b0;
  endtask

  // One pass starting in the current cycle (t). abort_at / rst_at > 0 assert
  // abort / rst during that cycle offset from t. noise pulses start/load
  // while busy.
  task automatic run_pass(input logic [MAX_LEN-1:0] p, input int li, input bit ld,
                          input int abort_at, input int rst_at, input bit noise);
    int L, eb, dc, last, nh, fi;
    int hits[$];
    logic [3:0] win;
    if (ld) begin
      m_pat = p;
      m_len = clamp_len(li);
    end
    L   = m_len;
    win = '0;
    // Stream bit i is pattern bit L-1-i; a hit at i ends a "1101" window.
    for (int i = 0; i < L; i++) begin
      win = {win[2:0], m_pat[L-1-i]};
      if (i >= 3 && win == 4'b1101) hits.push_back(i);
    end
    eb   = (L == 0) ? 1 : 1 + L + DET_LAT;
    dc   = eb + 1;
    last = (abort_at > 0) ? abort_at : ((rst_at > 0) ? rst_at : dc);
    nh   = 0;
    fi   = 0;

    load   = ld;
    pat_in = p;
    len_in = LEN_W'(li);
    start  = 1'b1;
    for (int c = 1; c <= last; c++) begin
      step();
      load   = 1'b0;
      start  = 1'b0;
      pat_in = {$urandom, $urandom};
      len_in = LEN_W'($urandom);
      // Hit for bit i is sampled in cycle 2+i+DET_LAT, visible one later.
      nh = 0;
      fi = 0;
      foreach (hits[k]) begin
        if (2 + hits[k] + DET_LAT < c) begin
          if (nh == 0) fi = hits[k];
          nh++;
        end
      end
      chk("busy",      busy,    (c <= eb));
      chk("det_rst",   det_rst, (c == 1));
      chk("det_din",   det_din, (c >= 2 && c < 2 + L) ? m_pat[L-1-(c-2)] : 1'b0);
      chk("done",      done,    (c == dc));
      chk("hit_cnt",   hit_cnt, nh);
      chk("first_vld", first_hit_vld, (nh > 0));
      chk("first_idx", first_hit_idx, fi);
      if (noise && c < last && $urandom_range(0, 1) == 1) begin
        start = 1'b1;
        load  = 1'b1;
      end
      if (c == last && abort_at > 0) abort = 1'b1;
      if (c == last && rst_at > 0) rst = 1'b1;
    end
    step();
    abort = 1'b0;
    rst   = 1'b0;
    load  = 1'b0;
    start = 1'b0;
    if (rst_at > 0) begin
      m_pat = '0;
      m_len = 0;
      nh    = 0;
      fi    = 0;
    end
    // Idle afterwards: results hold; an abort here must change nothing.
    for (int c = 0; c < 3; c++) begin
      chk("idle_busy",    busy,    1'b0);
      chk("idle_done",    done,    1'b0);
      chk("idle_det_rst", det_rst, 1'b0);
      chk("idle_det_din", det_din, 1'b0);
      chk("idle_hit_cnt", hit_cnt, nh);
      chk("idle_fvld",    first_hit_vld, (nh > 0));
      chk("idle_fidx",    first_hit_idx, fi);
      abort = (c == 0);
      step();
      abort = 1'b0;
    end
    n_txn++;
    $display("txn %0d: pat=%016h L=%0d abort@%0d rst@%0d hits=%0d first=%0d",
             n_txn, p, L, abort_at, rst_at, nh, fi);
  endtask

  initial begin
    logic [MAX_LEN-1:0] rp;
    int rl, rlc, ab;

    rst = 1'b1;
    step();
    step();
    chk("rst_busy",    busy,          1'b0);
    chk("rst_done",    done,          1'b0);
    chk("rst_det_rst", det_rst,       1'b0);
    chk("rst_det_din", det_din,       1'b0);
    chk("rst_hit_cnt", hit_cnt,       0);
    chk("rst_fidx",    first_hit_idx, 0);
    chk("rst_fvld",    first_hit_vld, 1'b0);
    rst = 1'b0;
    step();

    // 11011011, L=8: two hits, first at index 3.
    run_pass(64'hDB, 8, 1'b1, 0, 0, 1'b0);
    chk("s1_hits",  hit_cnt,       2);
    chk("s1_fidx",  first_hit_idx, 3);
    chk("s1_fvld",  first_hit_vld, 1'b1);

    // 0000, L=4, loaded in a separate cycle.
    load_only(64'h0, 4);
    run_pass(64'h0, 4, 1'b0, 0, 0, 1'b0);
    chk("zero_hits", hit_cnt,       0);
    chk("zero_fvld", first_hit_vld, 1'b0);

    // Empty pass.
    run_pass(64'hFFFF_FFFF_FFFF_FFFF, 0, 1'b1, 0, 0, 1'b0);

    // Abort in cycle t+7 keeps the partial result.
    run_pass(64'hDB, 8, 1'b1, 7, 0, 1'b0);
    chk("abort_hits", hit_cnt,       1);
    chk("abort_fidx", first_hit_idx, 3);

    // start/load noise while busy.
    run_pass(64'hDB, 8, 1'b1, 0, 0, 1'b1);
    chk("noise_hits", hit_cnt,       2);
    chk("noise_fidx", first_hit_idx, 3);

    // Reset in cycle t+5, then a start with the cleared stored length,
    // then a normal reload.
    run_pass(64'hDB, 8, 1'b1, 0, 5, 1'b0);
    run_pass(64'h0, 0, 1'b0, 0, 0, 1'b0);
    run_pass(64'hDB, 8, 1'b1, 0, 0, 1'b0);

    // Length above MAX_LEN clamps.
    run_pass({$urandom, $urandom}, 100, 1'b1, 0, 0, 1'b0);

    // Random passes.
    for (int n = 0; n < 20; n++) begin
      rp  = {$urandom, $urandom};
      rl  = $urandom_range(0, 70);
      rlc = clamp_len(rl);
      ab  = 0;
      if ($urandom_range(0, 3) == 0)
        ab = $urandom_range(1, (rlc == 0) ? 1 : 1 + rlc + DET_LAT);
      if ($urandom_range(0, 1) == 1) begin
        load_only(rp, rl);
        run_pass(rp, rl, 1'b0, ab, 0, n[0]);
      end else begin
        run_pass(rp, rl, 1'b1, ab, 0, n[0]);
      end
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
